// File: rtl/sum_sat_fifo.sv
// sum_sat_fifo: saturating result FIFO behind a serial adder.
//
// Each accepted word is saturated on the way in. When cout=1 the entry holds all-ones
// with its sat flag set. When cout=0 the entry holds sum unchanged with its sat flag clear.
// The FIFO uses a valid/ready handshake on both sides and has no same-cycle bypass.
// A pushed word becomes visible at the head one edge after it is accepted.
//
// Ports:
//   clk         single clock; all state updates on its rising edge
//   asyn_reset  synchronous active-high reset, sampled on the rising edge of clk
//   sum         unsigned sum word from the adder
//   cout        carry-out accompanying sum
//   d_in_vld    sum/cout valid
//   d_in_rdy    block can accept sum/cout (level != depth)
//   d_out       saturated result at the FIFO head
//   d_out_sat   head entry was saturated
//   d_out_vld   head entry valid (level != 0)
//   d_out_rdy   consumer accepts the head entry
//   level       current occupancy, 0..depth
//   sat_cnt     count of saturated words accepted, sticks at 255
module sum_sat_fifo #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 4
) (
  input  logic                     clk,
  input  logic                     asyn_reset,
  input  logic [width-1:0]         sum,
  input  logic                     cout,
  input  logic                     d_in_vld,
  output logic                     d_in_rdy,
  output logic [width-1:0]         d_out,
  output logic                     d_out_sat,
  output logic                     d_out_vld,
  input  logic                     d_out_rdy,
  output logic [$clog2(depth):0]   level,
  output logic [7:0]               sat_cnt
);

  localparam int unsigned PtrW = $clog2(depth);
  localparam int unsigned LvlW = PtrW + 1;

  logic [width-1:0] data_mem [depth];
  logic             sat_mem  [depth];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0] level_q, level_d;
  logic [7:0]      sat_cnt_q, sat_cnt_d;

  logic push, pop;

  // Handshake flags depend on registered state only.
  assign d_in_rdy  = (level_q != LvlW'(depth));
  assign d_out_vld = (level_q != '0);
  assign push      = d_in_vld & d_in_rdy;
  assign pop       = d_out_vld & d_out_rdy;

  assign d_out     = data_mem[rd_ptr_q];
  assign d_out_sat = sat_mem[rd_ptr_q];
  assign level     = level_q;
  assign sat_cnt   = sat_cnt_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    sat_cnt_d = sat_cnt_q;
    // depth is a power of two, so pointer overflow is exactly the modulo-depth wrap.
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase
    if (push && cout && (sat_cnt_q != 8'hFF)) sat_cnt_d = sat_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      sat_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  // Storage is not reset. Stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (push && !asyn_reset) begin
      data_mem[wr_ptr_q] <= cout ? {width{1'b1}} : sum;
      sat_mem[wr_ptr_q]  <= cout;
    end
  end

endmodule

// File: tb/tb_sum_sat_fifo.sv
module tb_sum_sat_fifo;

  logic       clk = 1'b0;
  logic       asyn_reset;
  logic [7:0] sum;
  logic       cout;
  logic       d_in_vld;
  logic       d_in_rdy;
  logic [7:0] d_out;
  logic       d_out_sat;
  logic       d_out_vld;
  logic       d_out_rdy;
  logic [2:0] level;
  logic [7:0] sat_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sum_sat_fifo #(.width(8), .depth(4)) dut (
    .clk       (clk),
    .asyn_reset(asyn_reset),
    .sum       (sum),
    .cout      (cout),
    .d_in_vld  (d_in_vld),
    .d_in_rdy  (d_in_rdy),
    .d_out     (d_out),
    .d_out_sat (d_out_sat),
    .d_out_vld (d_out_vld),
    .d_out_rdy (d_out_rdy),
    .level     (level),
    .sat_cnt   (sat_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_seq [5];
  logic       acc;

  initial begin
    asyn_reset = 1'b1;
    sum        = 8'h00;
    cout       = 1'b0;
    d_in_vld   = 1'b0;
    d_out_rdy  = 1'b0;
    step();
    step();
    check("rst_level", level, 0);
    check("rst_out_vld", d_out_vld, 0);
    check("rst_in_rdy", d_in_rdy, 1);
    check("rst_sat_cnt", sat_cnt, 0);

    // First push on the first edge after reset falls.
    asyn_reset = 1'b0;
    sum = 8'h3C; cout = 1'b0; d_in_vld = 1'b1;
    step();
    d_in_vld = 1'b0;
    check("p1_vld", d_out_vld, 1);
    check("p1_data", d_out, 8'h3C);
    check("p1_sat", d_out_sat, 0);
    check("p1_level", level, 1);
    d_out_rdy = 1'b1;
    step();
    d_out_rdy = 1'b0;
    check("p1_pop_level", level, 0);
    check("p1_pop_vld", d_out_vld, 0);

    // Saturating push.
    sum = 8'h12; cout = 1'b1; d_in_vld = 1'b1;
    step();
    d_in_vld = 1'b0;
    check("sat_data", d_out, 8'hFF);
    check("sat_flag", d_out_sat, 1);
    check("sat_cnt1", sat_cnt, 1);
    // Idle inputs are ignored even with cout high.
    sum = 8'hAA; cout = 1'b1;
    step();
    check("idle_sat_cnt", sat_cnt, 1);
    check("idle_level", level, 1);
    d_out_rdy = 1'b1;
    step();
    d_out_rdy = 1'b0;
    check("sat_pop_level", level, 0);

    // Fill to full, hold a 5th word, then drain.
    cout = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      sum = 8'(i); d_in_vld = 1'b1;
      step();
    end
    check("full_level", level, 4);
    check("full_in_rdy", d_in_rdy, 0);
    sum = 8'h05;
    step();
    step();
    check("full_hold_level", level, 4);
    check("full_hold_head", d_out, 8'h01);
    exp_seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    d_out_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("drain_vld", d_out_vld, 1);
      check($sformatf("drain_data%0d", i), d_out, exp_seq[i]);
      acc = d_in_vld & d_in_rdy;
      step();
      if (acc) d_in_vld = 1'b0;
    end
    check("drain_level", level, 0);
    check("drain_empty", d_out_vld, 0);

    // Streaming with the consumer always ready; pointers wrap more than twice.
    for (int i = 0; i < 10; i++) begin
      sum = 8'h10 + 8'(i); d_in_vld = 1'b1;
      step();
      check($sformatf("stream_level%0d", i), level, 1);
      check($sformatf("stream_data%0d", i), d_out, 8'h10 + 32'(i));
    end
    d_in_vld = 1'b0;
    step();
    check("stream_end_level", level, 0);

    // Reset with level=3 and a push and pop pending.
    d_out_rdy = 1'b0;
    cout = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sum = 8'h20 + 8'(i); d_in_vld = 1'b1;
      step();
    end
    check("pre_rst_level", level, 3);
    check("pre_rst_sat_cnt", sat_cnt, 4);
    d_out_rdy = 1'b1;
    asyn_reset = 1'b1;
    step();
    check("mid_rst_level", level, 0);
    check("mid_rst_vld", d_out_vld, 0);
    check("mid_rst_sat_cnt", sat_cnt, 0);
    check("mid_rst_in_rdy", d_in_rdy, 1);
    asyn_reset = 1'b0;

    // sat_cnt saturation over 300 pushes.
    cout = 1'b1; sum = 8'h00; d_in_vld = 1'b1; d_out_rdy = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i == 254) check("satcnt_254", sat_cnt, 254);
      if (i == 255) check("satcnt_255", sat_cnt, 255);
    end
    check("satcnt_300", sat_cnt, 255);
    d_in_vld = 1'b0;
    step();
    check("final_level", level, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
